rf_wr_ctrl: RTL and testbench
=============================

# rf_wr_ctrl

Write-port controller for the 32-entry register file (`rf_2`). After reset, or on request, it runs an initialization sweep that writes a constant to every register. Outside the sweep it arbitrates the single register-file write port between two requesters, writeback (req0) and load return (req1), with a round-robin valid/ready handshake. All register-file write outputs are registered.

## Interface
Parameters:
- `NUM_REGS`, 32, number of registers swept; must equal 2**`ADDR_W`.
- `ADDR_W`, 5, register select width.
- `DATA_W`, 32, data width.
- `INIT_VAL`, 0, value written to every register during the sweep.
- `R0_HARDWIRED`, 1, if 1, requester writes to register 0 are accepted and dropped.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `init_req` in 1: start or restart the initialization sweep.
- `busy` out 1: high while the sweep is running.
- `init_done` out 1: one-cycle pulse, coincident with the last sweep write.
- `req0_valid` in 1, `req0_ready` out 1, `req0_sel` in `ADDR_W`, `req0_data` in `DATA_W`: requester 0.
- `req1_valid` in 1, `req1_ready` out 1, `req1_sel` in `ADDR_W`, `req1_data` in `DATA_W`: requester 1.
- `rf_write` out 1, `rf_writeregsel` out `ADDR_W`, `rf_writedata` out `DATA_W`: to the register file write port.

## Operation
States:
- SWEEP: register-file writes come from the internal counter `cnt`.
- RUN: register-file writes come from arbitrated requests.

Reset behaviour:
- `rst` high: state=SWEEP, `cnt`=0, `last`=1.
- Registered outputs: `rf_write`=0, `rf_writeregsel`=0, `rf_writedata`=0, `init_done`=0.
- `busy`=1 (decoded directly from state).

SWEEP, each cycle:
- Register `rf_write`=1, `rf_writeregsel`=`cnt`, `rf_writedata`=`INIT_VAL`.
- When `cnt`==`NUM_REGS`-1: also register `init_done`=1, go to RUN, `cnt`=0. Otherwise `cnt`++.
- `init_req` high in SWEEP: `cnt` returns to 0 next cycle (restart); `init_done` is not pulsed for the abandoned sweep.

RUN:
- `init_req` high: go to SWEEP with `cnt`=0. No grant is issued that cycle; both readies are low.
- Otherwise arbitrate:
  - One valid: grant that requester.
  - Both valid: grant the requester that is not `last`.
- `reqN_ready` = (state==RUN) & !`init_req` & grantN.
  - Ready may depend on valid; requesters must not make valid depend on ready.
- On handshake (valid & ready):
  - `last`=N.
  - Register `rf_writeregsel`=`reqN_sel` and `rf_writedata`=`reqN_data`.
  - Register `rf_write`=1, except when `R0_HARDWIRED`=1 and `reqN_sel`==0, where `rf_write`=0 (write dropped, handshake still completes).
- No handshake: register `rf_write`=0; sel and data hold their previous values.
- `busy` = (state==SWEEP), combinational from state.

## Timing
- Request latency: handshake in cycle N gives `rf_write` high in cycle N+1. Throughput is one write per cycle.
- Sweep length: reset released at cycle 0 (first cycle `rst` low).
  - Sweep writes appear at cycles 1..`NUM_REGS`, with sel 0..`NUM_REGS`-1.
  - `init_done`=1 at cycle `NUM_REGS`, together with the write to sel `NUM_REGS`-1.
  - `busy` falls at cycle `NUM_REGS`; readies may rise that same cycle.
- `init_req` raised during the final sweep cycle (`cnt`==`NUM_REGS`-1): the restart takes precedence. Next state is SWEEP with `cnt`=0, and no `init_done` pulse.
- `rst` mid-sweep or mid-traffic: restores the reset values next cycle. Any pending handshake is discarded and the sweep restarts.
- Held valid with no grant: the requester must hold sel and data stable until ready.

## Test plan
- Reset then idle: release `rst` at cycle 0. `rf_write`=1 at cycles 1..32 with sel 0..31 and data 0. `init_done` pulses only at cycle 32. `busy` is low from cycle 32.
- Contention: after init, hold both valids with req0 sel 3/data 0xA, req1 sel 4/data 0xB for 4 cycles. Grants go req0, req1, req0, req1. The register file sees (3,0xA), (4,0xB), (3,0xA), (4,0xB) one cycle later.
- Single requester: only req1 valid with sel 7/data 0x55 for 3 cycles. `req1_ready`=1 every cycle, giving 3 consecutive writes of 0x55 to reg 7. `req0_ready`=0.
- R0 drop: req0 with sel 0/data 0xFFFF_FFFF. `req0_ready`=1, and next cycle `rf_write`=0. With `R0_HARDWIRED`=0, `rf_write`=1.
- Restart: pulse `init_req` at sweep `cnt`=10. Writes restart at sel 0, 32 more writes follow, and `init_done` pulses once.
- `init_req` in RUN with both valid: both readies are 0 that cycle. A full sweep follows, then arbitration resumes.

Source files
------------

// File: rtl/rf_wr_ctrl.sv
// Register-file write-port controller: init sweep after reset/init_req, then round-robin of two requesters.
// Latency: handshake to rf_write is 1 cycle; backpressure: readies low during sweep or init_req, else loser waits.
module rf_wr_ctrl #(
  parameter int                NUM_REGS     = 32,
  parameter int                ADDR_W       = 5,
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] INIT_VAL     = '0,
  parameter bit                R0_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  output logic              busy,
  output logic              init_done,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_sel,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_sel,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_writeregsel,
  output logic [DATA_W-1:0] rf_writedata
);

  typedef enum logic {SWEEP, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              last, last_nxt;
  logic              write_nxt, done_nxt;
  logic [ADDR_W-1:0] sel_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              grant0, grant1, run_open, hs0, hs1, cnt_end;

  // last==1 means req1 won most recently, so req0 has priority on a tie.
  assign grant0   = req0_valid & (~req1_valid | last);
  assign grant1   = req1_valid & (~req0_valid | ~last);
  assign run_open = (state == RUN) & ~init_req;

  assign req0_ready = run_open & grant0;
  assign req1_ready = run_open & grant1;
  assign hs0        = req0_valid & req0_ready;
  assign hs1        = req1_valid & req1_ready;
  assign busy       = (state == SWEEP);
  assign cnt_end    = (cnt == ADDR_W'(NUM_REGS - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    write_nxt = 1'b0;
    done_nxt  = 1'b0;
    sel_nxt   = rf_writeregsel;
    data_nxt  = rf_writedata;
    case (state)
      SWEEP: begin
        write_nxt = 1'b1;
        sel_nxt   = cnt;
        data_nxt  = INIT_VAL;
        if (init_req) begin
          cnt_nxt = '0;
        end else if (cnt_end) begin
          done_nxt  = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (init_req) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end else if (hs0) begin
          last_nxt  = 1'b0;
          sel_nxt   = req0_sel;
          data_nxt  = req0_data;
          write_nxt = !(R0_HARDWIRED && (req0_sel == '0));
        end else if (hs1) begin
          last_nxt  = 1'b1;
          sel_nxt   = req1_sel;
          data_nxt  = req1_data;
          write_nxt = !(R0_HARDWIRED && (req1_sel == '0));
        end
      end
      default: state_nxt = SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SWEEP;
      cnt            <= '0;
      last           <= 1'b1;
      rf_write       <= 1'b0;
      rf_writeregsel <= '0;
      rf_writedata   <= '0;
      init_done      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      last           <= last_nxt;
      rf_write       <= write_nxt;
      rf_writeregsel <= sel_nxt;
      rf_writedata   <= data_nxt;
      init_done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rf_wr_ctrl.sv
// Scoreboard bench for rf_wr_ctrl: directed test-plan phases, then randomized traffic, init_req and reset.
module tb_rf_wr_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst, init_req;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_sel, req1_sel;
  logic [DW-1:0] req0_data, req1_data;

  logic          busy_h, done_h, rdy0_h, rdy1_h, wr_h;
  logic [AW-1:0] wsel_h;
  logic [DW-1:0] wdat_h;
  logic          busy_n, done_n, rdy0_n, rdy1_n, wr_n;
  logic [AW-1:0] wsel_n;
  logic [DW-1:0] wdat_n;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_wr_ctrl #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .R0_HARDWIRED(1'b1)) dut_h (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy_h), .init_done(done_h),
    .req0_valid(req0_valid), .req0_ready(rdy0_h), .req0_sel(req0_sel), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(rdy1_h), .req1_sel(req1_sel), .req1_data(req1_data),
    .rf_write(wr_h), .rf_writeregsel(wsel_h), .rf_writedata(wdat_h));

  rf_wr_ctrl #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .R0_HARDWIRED(1'b0)) dut_n (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy_n), .init_done(done_n),
    .req0_valid(req0_valid), .req0_ready(rdy0_n), .req0_sel(req0_sel), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(rdy1_n), .req1_sel(req1_sel), .req1_data(req1_data),
    .rf_write(wr_n), .rf_writeregsel(wsel_n), .rf_writedata(wdat_n));

  // Expected register-file port contents for one cycle.
  typedef struct {
    bit            wr_h;
    bit            wr_n;
    logic [AW-1:0] sel;
    logic [DW-1:0] data;
    bit            done;
  } exp_t;

  exp_t q[$];

  // Reference model state: sweeping flag, sweep position, who won last, held port values.
  bit            started = 1'b0;
  bit            m_sweep = 1'b1;
  int            m_cnt   = 0;
  int            m_last  = 1;
  logic [AW-1:0] m_sel   = '0;
  logic [DW-1:0] m_data  = '0;

  function automatic int exp_grant();
    if (m_sweep || init_req) return -1;
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   g;
    if (rst) begin
      started = 1'b1;
      m_sweep = 1'b1;
      m_cnt   = 0;
      m_last  = 1;
      m_sel   = '0;
      m_data  = '0;
      e.wr_h = 1'b0; e.wr_n = 1'b0; e.sel = '0; e.data = '0; e.done = 1'b0;
      q.push_back(e);
    end else if (started) begin
      e.wr_h = 1'b0; e.wr_n = 1'b0; e.done = 1'b0;
      if (m_sweep) begin
        e.wr_h = 1'b1; e.wr_n = 1'b1;
        m_sel  = AW'(m_cnt);
        m_data = '0;
        if (init_req) begin
          m_cnt = 0;
        end else if (m_cnt == N - 1) begin
          e.done  = 1'b1;
          m_sweep = 1'b0;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end else if (init_req) begin
        m_sweep = 1'b1;
        m_cnt   = 0;
      end else begin
        g = exp_grant();
        if (g >= 0) begin
          m_last = g;
          m_sel  = (g == 1) ? req1_sel : req0_sel;
          m_data = (g == 1) ? req1_data : req0_data;
          e.wr_h = (m_sel != 0);
          e.wr_n = 1'b1;
        end
      end
      e.sel  = m_sel;
      e.data = m_data;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (started) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 64'd0, 64'd1);
      end else begin
        e = q.pop_front();
        chk("rf_write_h", wr_h, e.wr_h);
        chk("rf_write_n", wr_n, e.wr_n);
        chk("init_done_h", done_h, e.done);
        chk("init_done_n", done_n, e.done);
        chk("writeregsel_h", wsel_h, e.sel);
        chk("writeregsel_n", wsel_n, e.sel);
        chk("writedata_h", wdat_h, e.data);
        chk("writedata_n", wdat_n, e.data);
      end
      g = exp_grant();
      chk("req0_ready_h", rdy0_h, g == 0);
      chk("req1_ready_h", rdy1_h, g == 1);
      chk("req0_ready_n", rdy0_n, g == 0);
      chk("req1_ready_n", rdy1_n, g == 1);
      chk("busy_h", busy_h, m_sweep);
      chk("busy_n", busy_n, m_sweep);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic new_req(output logic v, output logic [AW-1:0] s, output logic [DW-1:0] d);
    v = ($urandom_range(0, 3) != 0);
    s = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
    d = $urandom;
  endtask

  initial begin
    bit hs0, hs1;
    rst = 1'b1; init_req = 1'b0;
    req0_valid = 1'b0; req0_sel = '0; req0_data = '0;
    req1_valid = 1'b0; req1_sel = '0; req1_data = '0;
    cyc(2);
    rst = 1'b0;                       // cycle 0 begins
    cyc(10);
    init_req = 1'b1;                  // sweep cnt == 10
    cyc(1);
    init_req = 1'b0;
    cyc(40);

    req0_valid = 1'b1; req0_sel = 5'd3; req0_data = 32'hA;
    req1_valid = 1'b1; req1_sel = 5'd4; req1_data = 32'hB;
    cyc(4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(2);

    req1_valid = 1'b1; req1_sel = 5'd7; req1_data = 32'h55;
    cyc(3);
    req1_valid = 1'b0;
    cyc(1);

    req0_valid = 1'b1; req0_sel = 5'd0; req0_data = 32'hFFFF_FFFF;
    cyc(1);
    req0_valid = 1'b0;
    cyc(2);

    req0_valid = 1'b1; req0_sel = 5'd3; req0_data = 32'hA;
    req1_valid = 1'b1; req1_sel = 5'd4; req1_data = 32'hB;
    init_req = 1'b1;
    cyc(1);
    init_req = 1'b0;
    cyc(36);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(2);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hs0 = req0_valid && rdy0_h;
      hs1 = req1_valid && rdy1_h;
      @(posedge clk);
      #1;
      if (!req0_valid || hs0) new_req(req0_valid, req0_sel, req0_data);
      if (!req1_valid || hs1) new_req(req1_valid, req1_sel, req1_data);
      init_req = ($urandom_range(0, 149) == 0);
      rst      = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0; init_req = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(3);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
